// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial add/subtract sequencer.
//
// A single full adder processes one operand bit per clock, LSB first, over
// WIDTH cycles. A carry flip-flop links consecutive bits. The operands are
// held in right-shifting registers. The sum bits shift into the MSB of the
// result register, so the complete answer is lined up after WIDTH shifts.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-high reset
//   start      request, sampled only in IDLE
//   sub        0 = a_in + b_in, 1 = a_in - b_in (sampled with start)
//   a_in/b_in  WIDTH-bit operands (sampled with start)
//   busy       high while the adder is running
//   done       one-cycle pulse when result is valid
//   result     sum/difference, held until the next operation runs
//   carry_out  final adder carry (subtract: 1 = no borrow), held with result
//   overflow   signed overflow; exists only when SERIAL_ADD_OVF_EN is defined
//
// Build option: define SERIAL_ADD_OVF_EN to add the overflow port and logic.

module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);
    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

module serial_add_ctrl #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_out
`ifdef SERIAL_ADD_OVF_EN
    ,
    output logic             overflow
`endif
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    logic [1:0]       state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic             c_ff;
    logic [CNT_W-1:0] count;
    logic             fa_sum;
    logic             fa_cout;

    full_adder u_fa (
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .cin  (c_ff),
        .sum  (fa_sum),
        .cout (fa_cout)
    );

    assign busy = (state == RUN);
    assign done = (state == DONE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            a_sh      <= '0;
            b_sh      <= '0;
            c_ff      <= 1'b0;
            count     <= '0;
            result    <= '0;
            carry_out <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
            overflow  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        // Subtract is A + ~B + 1: invert B now and seed the carry with 1.
                        a_sh  <= a_in;
                        b_sh  <= sub ? ~b_in : b_in;
                        c_ff  <= sub;
                        count <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    result <= {fa_sum, result[WIDTH-1:1]};
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    c_ff   <= fa_cout;
                    count  <= count + CNT_W'(1);
                    if (count == LAST) begin
                        // The MSB is being added: capture the final carry and overflow flags.
                        carry_out <= fa_cout;
`ifdef SERIAL_ADD_OVF_EN
                        overflow  <= c_ff ^ fa_cout;
`endif
                        state     <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule
